// File: rtl/sparc_isa_pkg.sv
// rtl/sparc_isa_pkg.sv - SPARC instruction field positions, op encodings, decoded field bundle
// Purpose: shared constants and types for the instruction field latch.
//   Field bit positions, op encodings, illegal op2/op3 lists, the decoded
//   field struct, the skid-stage state type and an illegal-encoding helper.
package sparc_isa_pkg;

    localparam int OP_HI     = 31;
    localparam int OP_LO     = 30;
    localparam int RD_HI     = 29;
    localparam int RD_LO     = 25;
    localparam int OP2_HI    = 24;
    localparam int OP2_LO    = 22;
    localparam int OP3_HI    = 24;
    localparam int OP3_LO    = 19;
    localparam int RS1_HI    = 18;
    localparam int RS1_LO    = 14;
    localparam int I_BIT     = 13;
    localparam int RS2_HI    = 4;
    localparam int RS2_LO    = 0;
    localparam int SIMM13_HI = 12;
    localparam int SIMM13_LO = 0;
    localparam int DISP22_HI = 21;
    localparam int DISP22_LO = 0;
    localparam int DISP30_HI = 29;
    localparam int DISP30_LO = 0;
    localparam int COND_HI   = 28;
    localparam int COND_LO   = 25;
    localparam int ANNUL_BIT = 29;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [1:0] OP_ARITH  = 2'b10;
    localparam logic [1:0] OP_MEM    = 2'b11;

    // Unimplemented format-2 op2 values, packed 3 bits per entry.
    localparam int               N_ILL_OP2    = 4;
    localparam logic [3*4-1:0]   ILL_OP2_LIST = {3'b000, 3'b001, 3'b011, 3'b101};

    // Unimplemented format-3 (op=10) op3 values, packed 6 bits per entry.
    localparam int               N_ILL_OP3    = 5;
    localparam logic [6*5-1:0]   ILL_OP3_LIST = {6'h09, 6'h0D, 6'h19, 6'h1D, 6'h2D};

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [2:0]  op2;
        logic [5:0]  op3;
        logic [4:0]  rs1;
        logic        i;
        logic [4:0]  rs2;
        logic [12:0] simm13;
        logic [21:0] disp22;
        logic [29:0] disp30;
        logic [3:0]  cond;
        logic        annul;
    } sparc_fields_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    function automatic logic is_illegal(input logic [31:0] word);
        logic ill;
        ill = 1'b0;
        if (word[OP_HI:OP_LO] == OP_BRANCH) begin
            for (int k = 0; k < N_ILL_OP2; k++) begin
                if (word[OP2_HI:OP2_LO] == ILL_OP2_LIST[k*3 +: 3]) ill = 1'b1;
            end
        end
        if (word[OP_HI:OP_LO] == OP_ARITH) begin
            for (int k = 0; k < N_ILL_OP3; k++) begin
                if (word[OP3_HI:OP3_LO] == ILL_OP3_LIST[k*6 +: 6]) ill = 1'b1;
            end
        end
        return ill;
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// rtl/instr_field_split.sv - combinational slicing of a SPARC word into its format fields
// Ports:
//   instr  in  32  raw instruction word
//   fields out     sparc_fields_t, every format field driven at once
module instr_field_split
    import sparc_isa_pkg::*;
(
    input  logic [31:0]   instr,
    output sparc_fields_t fields
);

    always_comb begin
        fields.op     = instr[OP_HI:OP_LO];
        fields.rd     = instr[RD_HI:RD_LO];
        fields.op2    = instr[OP2_HI:OP2_LO];
        fields.op3    = instr[OP3_HI:OP3_LO];
        fields.rs1    = instr[RS1_HI:RS1_LO];
        fields.i      = instr[I_BIT];
        fields.rs2    = instr[RS2_HI:RS2_LO];
        fields.simm13 = instr[SIMM13_HI:SIMM13_LO];
        fields.disp22 = instr[DISP22_HI:DISP22_LO];
        fields.disp30 = instr[DISP30_HI:DISP30_LO];
        fields.cond   = instr[COND_HI:COND_LO];
        fields.annul  = instr[ANNUL_BIT];
    end

endmodule

// File: rtl/instr_field_latch.sv
// rtl/instr_field_latch.sv - 2-entry skid stage presenting pre-split SPARC instruction fields
// Optional macro: ILLEGAL_CHECK_EN (registers an illegal-encoding flag per entry).
// Ports:
//   clk, reset_n (async, active low), flush (sync discard)
//   in_valid/in_ready/in_instr/in_pc     upstream handshake
//   out_valid/out_ready/out_pc           downstream handshake
//   out_op .. out_annul                  fields sliced from the main register
//   out_illegal                          illegal-encoding flag (0 without the macro)
module instr_field_latch
    import sparc_isa_pkg::*;
#(
    parameter int IW   = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_op2,
    output logic [5:0]      out_op3,
    output logic [4:0]      out_rs1,
    output logic            out_i,
    output logic [4:0]      out_rs2,
    output logic [12:0]     out_simm13,
    output logic [21:0]     out_disp22,
    output logic [29:0]     out_disp30,
    output logic [3:0]      out_cond,
    output logic            out_annul,
    output logic            out_illegal
);

    stage_state_t    state_q, state_d;
    logic            in_ready_q;
    logic [IW-1:0]   main_instr_q, skid_instr_q;
    logic [PC_W-1:0] main_pc_q, skid_pc_q;

    logic accept, consume;
    logic load_main_in, load_main_skid, load_skid;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_FULL;
                    load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = ST_SKID;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                // in_ready is low here, so only a consume can move the stage.
                if (consume) begin
                    state_d        = ST_FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush overrides everything; a word accepted in the same cycle is dropped.
        if (flush) begin
            state_d        = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Registered from the next state so upstream never sees out_ready combinationally.
            in_ready_q <= (state_d != ST_SKID);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            if (load_main_in) begin
                main_instr_q <= in_instr;
                main_pc_q    <= in_pc;
            end else if (load_main_skid) begin
                main_instr_q <= skid_instr_q;
                main_pc_q    <= skid_pc_q;
            end
            if (load_skid) begin
                skid_instr_q <= in_instr;
                skid_pc_q    <= in_pc;
            end
        end
    end

`ifdef ILLEGAL_CHECK_EN
    logic main_ill_q, skid_ill_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_ill_q <= 1'b0;
            skid_ill_q <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_ill_q <= is_illegal(in_instr);
            end else if (load_main_skid) begin
                main_ill_q <= skid_ill_q;
            end
            if (load_skid) begin
                skid_ill_q <= is_illegal(in_instr);
            end
        end
    end

    assign out_illegal = main_ill_q;
`else
    assign out_illegal = 1'b0;
`endif

    sparc_fields_t fields;

    instr_field_split u_split (
        .instr  (main_instr_q),
        .fields (fields)
    );

    assign out_pc     = main_pc_q;
    assign out_op     = fields.op;
    assign out_rd     = fields.rd;
    assign out_op2    = fields.op2;
    assign out_op3    = fields.op3;
    assign out_rs1    = fields.rs1;
    assign out_i      = fields.i;
    assign out_rs2    = fields.rs2;
    assign out_simm13 = fields.simm13;
    assign out_disp22 = fields.disp22;
    assign out_disp30 = fields.disp30;
    assign out_cond   = fields.cond;
    assign out_annul  = fields.annul;

endmodule

// File: tb/tb_instr_field_latch.sv
// tb/tb_instr_field_latch.sv - scoreboard bench for instr_field_latch
module tb_instr_field_latch;

`ifdef ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc;
    logic [1:0]  out_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_op2;
    logic [5:0]  out_op3;
    logic        out_i, out_annul, out_illegal;
    logic [12:0] out_simm13;
    logic [21:0] out_disp22;
    logic [29:0] out_disp30;
    logic [3:0]  out_cond;

    always #5 clk = ~clk;

    instr_field_latch #(.IW(32), .PC_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_op(out_op), .out_rd(out_rd), .out_op2(out_op2), .out_op3(out_op3),
        .out_rs1(out_rs1), .out_i(out_i), .out_rs2(out_rs2), .out_simm13(out_simm13),
        .out_disp22(out_disp22), .out_disp30(out_disp30), .out_cond(out_cond),
        .out_annul(out_annul), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic        cur_ill;
    logic [129:0] act;

    assign act = {out_pc, out_op, out_rd, out_op2, out_op3, out_rs1, out_i, out_rs2,
                  out_simm13, out_disp22, out_disp30, out_cond, out_annul, out_illegal};

    function automatic logic [129:0] model(input logic [31:0] w, input logic [31:0] pc, input logic ill);
        return {pc, w[31:30], w[29:25], w[24:22], w[24:19], w[18:14], w[13], w[4:0],
                w[12:0], w[21:0], w[29:0], w[28:25], w[29], ill};
    endfunction

    task automatic chk(input string name, input logic [129:0] a, input logic [129:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, a, e);
        end
    endtask

    // Monitor: pops and compares on every consume, then records accepted words.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output act=%h exp=none", act);
                end else begin
                    mon_e = sb.pop_front();
                    pops++;
                    chk("sb_entry", act, model(mon_e.instr, mon_e.pc, mon_e.ill));
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back('{in_instr, in_pc, cur_ill});
        end
    end

    always @(negedge reset_n) sb.delete();

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] pc, input logic ill);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        cur_ill  = ILL_EN & ill;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    logic [31:0] words [8];
    logic        ills  [8];

    initial begin
        words = '{32'h00000000, 32'h01000000, 32'h10800005, 32'h81C3E008,
                  32'hC2006004, 32'h80480000, 32'h81680000, 32'h01400000};
        ills  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; cur_ill = 1'b0;

        #12;
        chk("reset_valid", out_valid, 0);
        chk("reset_fields", act, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        chk("ready_after_reset", in_ready, 1);

        // Single word with hand-decoded fields
        out_ready = 1'b1;
        offer(32'h8A007FFF, 32'h100, 1'b0);
        cyc();
        idle();
        chk("t1_valid", out_valid, 1);
        chk("t1_op", out_op, 2);
        chk("t1_rd", out_rd, 5);
        chk("t1_op3", out_op3, 0);
        chk("t1_rs1", out_rs1, 1);
        chk("t1_i", out_i, 1);
        chk("t1_simm13", out_simm13, 13'h1FFF);
        chk("t1_pc", out_pc, 32'h100);
        cyc();
        chk("t1_drained", out_valid, 0);

        // Fill to SKID with out_ready low, then drain in order
        out_ready = 1'b0;
        offer(32'h8A007FFF, 32'h104, 1'b0);
        cyc();
        offer(32'h40000004, 32'h108, 1'b0);
        cyc();
        idle();
        chk("t2_ready_low", in_ready, 0);
        chk("t2_simm13", out_simm13, 13'h1FFF);
        cyc();
        chk("t2_hold_pc", out_pc, 32'h104);
        out_ready = 1'b1;
        cyc();
        chk("t2_op_call", out_op, 1);
        chk("t2_disp30", out_disp30, 30'h4);
        chk("t2_pc2", out_pc, 32'h108);
        chk("t2_ready_back", in_ready, 1);
        cyc();
        chk("t2_drained", out_valid, 0);

        // Streaming, one word per cycle
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            offer(words[k], 32'h200 + 32'(4 * k), ills[k]);
            cyc();
            chk("t3_ready", in_ready, 1);
            chk("t3_valid", out_valid, 1);
        end
        idle();
        cyc();
        chk("t3_drained", out_valid, 0);

        // Flush in SKID with in_valid high
        out_ready = 1'b0;
        offer(32'h8A007FFF, 32'h300, 1'b0);
        cyc();
        offer(32'h40000004, 32'h304, 1'b0);
        cyc();
        chk("t4_skid", in_ready, 0);
        flush = 1'b1;
        offer(32'h01000000, 32'h308, 1'b0);
        cyc();
        flush = 1'b0;
        idle();
        chk("t4_flush_valid", out_valid, 0);
        chk("t4_flush_ready", in_ready, 1);

        // Flush beats a simultaneous accept
        offer(32'h10800005, 32'h30C, 1'b0);
        cyc();
        offer(32'hC2006004, 32'h310, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        chk("t4_flush_accept_valid", out_valid, 0);
        chk("t4_flush_accept_ready", in_ready, 1);

        // Flush together with consume
        offer(32'h81C3E008, 32'h314, 1'b0);
        cyc();
        idle();
        out_ready = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t4_flush_consume", out_valid, 0);

        // Asynchronous reset while in SKID
        out_ready = 1'b0;
        offer(32'h80480000, 32'h400, 1'b1);
        cyc();
        offer(32'h81680000, 32'h404, 1'b1);
        cyc();
        idle();
        chk("t5_skid", in_ready, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_fields", act, 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        cyc();
        chk("t5_ready_after", in_ready, 1);

        // Illegal flag
        out_ready = 1'b1;
        offer(32'h00000000, 32'h500, 1'b1);
        cyc();
        idle();
        chk("t6_illegal_zero", out_illegal, ILL_EN);
        cyc();
        offer(32'h8A007FFF, 32'h504, 1'b0);
        cyc();
        idle();
        chk("t6_legal_add", out_illegal, 0);
        cyc();
        cyc();

        chk("sb_empty", sb.size(), 0);
        chk("pop_count", pops, 14);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/instr_field_latch.md
Name: instr_field_latch

Overview:
- Pipeline stage between instruction memory and the operand path of the SPARC datapath.
- Captures 32-bit instruction words under a valid/ready handshake, buffered through a 2-entry skid buffer.
- Presents registered, pre-split SPARC format fields; the raw simm13 field feeds the sign extender, and rs1/rs2/rd feed the register file.
- Supports a synchronous flush for branch annulment.

Parameters:
- IW, 32, instruction word width; only 32 is supported.
- PC_W, 32, width of the PC carried alongside each instruction.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  instruction word offered
- in_ready  out  1  stage can accept a word
- in_instr  in  32  raw instruction word
- in_pc  in  PC_W  address of in_instr
- out_valid  out  1  decoded entry present
- out_ready  in  1  downstream consumes the entry
- out_pc  out  PC_W  PC of the presented entry
- out_op  out  2  bits [31:30]
- out_rd  out  5  bits [29:25]
- out_op2  out  3  bits [24:22]
- out_op3  out  6  bits [24:19]
- out_rs1  out  5  bits [18:14]
- out_i  out  1  bit [13]
- out_rs2  out  5  bits [4:0]
- out_simm13  out  13  bits [12:0], not sign-extended
- out_disp22  out  22  bits [21:0]
- out_disp30  out  30  bits [29:0]
- out_cond  out  4  bits [28:25]
- out_annul  out  1  bit [29]
- out_illegal  out  1  illegal-encoding flag; constant 0 unless ILLEGAL_CHECK_EN is defined

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to EMPTY.
  - out_valid=0; all out_* fields 0.
  - in_ready=1 from the first clock after reset release.
- States:
  - EMPTY: no entry held.
  - FULL: main register valid.
  - SKID: main and skid registers both valid.
- Handshake:
  - A transfer occurs when valid && ready at a rising edge.
  - in_ready is registered and equals (state != SKID). It has no combinational path from out_ready.
- Transitions:
  - EMPTY + accept -> FULL. Latency from accept to out_valid is 1 cycle.
  - FULL + accept, no consume -> SKID; the word goes to the skid register.
  - FULL + accept + consume -> FULL; the main register loads the new word.
  - FULL + consume only -> EMPTY.
  - SKID + consume -> FULL; the skid entry moves to main. No accept is possible in SKID because in_ready=0.
- Ordering: strictly FIFO. No word is dropped or duplicated.
- Output stability: while out_valid && !out_ready, all out_* fields hold their values.
- Field extraction:
  - Pure bit slicing of the main register; no arithmetic.
  - Overlapping fields (op2/op3, rd/cond/annul, disp22/simm13) are all driven at once; the consumer selects by out_op.
- flush:
  - Next state is EMPTY; out_valid=0 next cycle; in_ready=1 next cycle.
  - flush wins over a simultaneous accept: that word is discarded, although the upstream saw in_ready=1 and treats it as taken.
  - flush and consume in the same cycle count as one consume, and the flush still empties the stage.
- Reset mid-operation: both entries are lost immediately (asynchronous); there is no partial output.

Optional Feature:
- Macro: ILLEGAL_CHECK_EN.
- Defined: out_illegal is registered alongside the entry. It is 1 when either:
  - op=00 and op2 is in {000, 001, 011, 101}, or
  - op=10 and op3 is in {0x09, 0x0D, 0x19, 0x1D, 0x2D}.
  - The flag follows its entry through the skid register.
- Undefined: out_illegal is tied to 0 and no check logic is synthesized.

Decomposition:
- Package sparc_isa_pkg:
  - field bit-position constants (OP_HI/LO, RD_HI/LO, …);
  - op encodings OP_BRANCH=2'b00, OP_CALL=2'b01, OP_ARITH=2'b10, OP_MEM=2'b11;
  - illegal op2/op3 constant lists;
  - a struct typedef for the decoded field bundle.
- Sub-module instr_field_split: combinational slicing of a 32-bit word into that struct. Instantiate it once on the main register output.
- The skid/handshake logic stays in the top module.

Test Plan:
- Reset released, then accept 0x8A007FFF (add %g1,-1,%g5) with pc 0x100 -> next cycle out_valid=1, out_op=2, out_rd=5, out_op3=0, out_rs1=1, out_i=1, out_simm13=0x1FFF, out_pc=0x100.
- Hold out_ready=0 and offer 0x8A007FFF then 0x40000004 -> in_ready falls to 0 after the second accept. Raise out_ready -> outputs 0x8A007FFF, then op=1 with out_disp30=0x4. No loss, FIFO order kept.
- Continuous in_valid=1 and out_ready=1 over 8 words -> one word per cycle, in_ready stays 1, outputs appear in order 1 cycle late.
- In SKID state assert flush together with in_valid -> next cycle out_valid=0 and in_ready=1; the flushed words never appear on the outputs.
- Drop reset_n to 0 mid-stream while state=SKID -> out_valid=0 and all fields 0 immediately, without waiting for a clock edge.
- With ILLEGAL_CHECK_EN defined, accept 0x00000000 (op=0, op2=000) -> out_illegal=1; accept 0x8A007FFF -> out_illegal=0. Without the macro, out_illegal=0 for both.
